// File: rtl/mips_pkg.sv
// Shared MIPS encodings: opcodes, R-type function codes, ALU control values and
// the decoded control bundle used by the decode stage.
package mips_pkg;

  localparam int REG_ADDR_W = 5;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alu_ctrl_e;

  typedef struct packed {
    logic      reg_write;
    logic      mem_to_reg;
    logic      mem_write;
    logic      alu_src;
    logic      reg_dst;
    logic      branch;
    logic      jump;
    alu_ctrl_e alu_ctrl;
  } ctrl_t;

  // Unknown opcodes decode to all-zero control; an R-type with an unknown
  // funct keeps RegDst set but otherwise behaves as a NOP.
  function automatic ctrl_t decode_ctrl(input logic [5:0] op, input logic [5:0] funct);
    ctrl_t c;
    c = '0;
    case (op)
      OP_RTYPE: begin
        c.reg_dst = 1'b1;
        c.reg_write = 1'b1;
        case (funct)
          FN_ADD:  c.alu_ctrl = ALU_ADD;
          FN_SUB:  c.alu_ctrl = ALU_SUB;
          FN_AND:  c.alu_ctrl = ALU_AND;
          FN_OR:   c.alu_ctrl = ALU_OR;
          FN_SLT:  c.alu_ctrl = ALU_SLT;
          default: c.reg_write = 1'b0;
        endcase
      end
      OP_LW: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
        c.alu_src    = 1'b1;
        c.alu_ctrl   = ALU_ADD;
      end
      OP_SW: begin
        c.mem_write = 1'b1;
        c.alu_src   = 1'b1;
        c.alu_ctrl  = ALU_ADD;
      end
      OP_BEQ, OP_BNE: begin
        c.branch   = 1'b1;
        c.alu_ctrl = ALU_SUB;
      end
      OP_ADDI: begin
        c.reg_write = 1'b1;
        c.alu_src   = 1'b1;
        c.alu_ctrl  = ALU_ADD;
      end
      OP_J:    c.jump = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/register_file.sv
// Architectural register file: two combinational read ports with write-through
// bypass, one write port, register 0 hardwired to zero, async clear.
module register_file
  import mips_pkg::*;
#(
  parameter int NREGS = 32,
  parameter int WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] ra1,
  input  logic [REG_ADDR_W-1:0] ra2,
  output logic [WIDTH-1:0]      rd1,
  output logic [WIDTH-1:0]      rd2,
  input  logic                  we,
  input  logic [REG_ADDR_W-1:0] wa,
  input  logic [WIDTH-1:0]      wd
);

  logic [WIDTH-1:0] regs_q [NREGS];
  logic [WIDTH-1:0] regs_d [NREGS];
  logic             wr_en;

  assign wr_en = we && (wa != '0);

  always_comb begin
    regs_d = regs_q;
    if (wr_en) regs_d[wa] = wd;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  // The writeback value is visible to decode in the same cycle it is written.
  always_comb begin
    rd1 = regs_q[ra1];
    if (ra1 == '0)                 rd1 = '0;
    else if (wr_en && (wa == ra1)) rd1 = wd;
  end

  always_comb begin
    rd2 = regs_q[ra2];
    if (ra2 == '0)                 rd2 = '0;
    else if (wr_en && (wa == ra2)) rd2 = wd;
  end

endmodule

// File: rtl/decode_stage.sv
// MIPS decode stage: IF/ID register, register file, control decode and early
// branch/jump resolution returned to fetch in the same cycle.
module decode_stage
  import mips_pkg::*;
#(
  parameter int NREGS = 32,
  parameter int WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  StallD,
  input  logic [31:0]           InstrF,
  input  logic [31:0]           PCPlus4F,
  input  logic                  ForwardAD,
  input  logic                  ForwardBD,
  input  logic [WIDTH-1:0]      ALUOutM,
  input  logic                  RegWriteW,
  input  logic [REG_ADDR_W-1:0] WriteRegW,
  input  logic [WIDTH-1:0]      ResultW,
  output logic                  PCSrcD,
  output logic                  Jump,
  output logic [31:0]           PCBranchD,
  output logic [31:0]           PCJumpD,
  output logic [WIDTH-1:0]      RD1D,
  output logic [WIDTH-1:0]      RD2D,
  output logic [REG_ADDR_W-1:0] RsD,
  output logic [REG_ADDR_W-1:0] RtD,
  output logic [REG_ADDR_W-1:0] RdD,
  output logic [31:0]           SignImmD,
  output logic                  RegWriteD,
  output logic                  MemtoRegD,
  output logic                  MemWriteD,
  output logic                  ALUSrcD,
  output logic                  RegDstD,
  output logic                  BranchD,
  output logic [2:0]            ALUControlD
);

  logic [31:0]        instr_q, instr_d;
  logic [31:0]        pcplus4_q, pcplus4_d;
  ctrl_t              ctrl;
  logic signed [31:0] sign_imm;
  logic [WIDTH-1:0]   src_a, src_b;
  logic               operands_eq;

  // IF/ID register: stall beats flush so a stalled branch keeps its state.
  always_comb begin
    instr_d   = instr_q;
    pcplus4_d = pcplus4_q;
    if (!StallD) begin
      if (PCSrcD || Jump) begin
        instr_d   = '0;
        pcplus4_d = '0;
      end else begin
        instr_d   = InstrF;
        pcplus4_d = PCPlus4F;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_q   <= '0;
      pcplus4_q <= '0;
    end else begin
      instr_q   <= instr_d;
      pcplus4_q <= pcplus4_d;
    end
  end

  register_file #(
    .NREGS(NREGS),
    .WIDTH(WIDTH)
  ) u_regfile (
    .clk (clk),
    .rst (rst),
    .ra1 (RsD),
    .ra2 (RtD),
    .rd1 (RD1D),
    .rd2 (RD2D),
    .we  (RegWriteW),
    .wa  (WriteRegW),
    .wd  (ResultW)
  );

  assign RsD = instr_q[25:21];
  assign RtD = instr_q[20:16];
  assign RdD = instr_q[15:11];

  assign ctrl        = decode_ctrl(instr_q[31:26], instr_q[5:0]);
  assign RegWriteD   = ctrl.reg_write;
  assign MemtoRegD   = ctrl.mem_to_reg;
  assign MemWriteD   = ctrl.mem_write;
  assign ALUSrcD     = ctrl.alu_src;
  assign RegDstD     = ctrl.reg_dst;
  assign BranchD     = ctrl.branch;
  assign Jump        = ctrl.jump;
  assign ALUControlD = ctrl.alu_ctrl;

  assign sign_imm = $signed(instr_q[15:0]);
  assign SignImmD = sign_imm;

  // Branch compare sits in decode, so M-stage results are forwarded here.
  assign src_a       = ForwardAD ? ALUOutM : RD1D;
  assign src_b       = ForwardBD ? ALUOutM : RD2D;
  assign operands_eq = (src_a == src_b);
  assign PCSrcD      = ctrl.branch &&
                       ((instr_q[31:26] == OP_BNE) ? !operands_eq : operands_eq);

  assign PCBranchD = pcplus4_q + {sign_imm[29:0], 2'b00};
  assign PCJumpD   = {pcplus4_q[31:28], instr_q[25:0], 2'b00};

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: expected outputs are queued as stimulus is
// applied and popped against the DUT once the decode outputs have settled.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        StallD = 1'b0;
  logic [31:0] InstrF = '0;
  logic [31:0] PCPlus4F = '0;
  logic        ForwardAD = 1'b0;
  logic        ForwardBD = 1'b0;
  logic [31:0] ALUOutM = '0;
  logic        RegWriteW = 1'b0;
  logic [4:0]  WriteRegW = '0;
  logic [31:0] ResultW = '0;

  logic        PCSrcD, Jump;
  logic [31:0] PCBranchD, PCJumpD, RD1D, RD2D, SignImmD;
  logic [4:0]  RsD, RtD, RdD;
  logic        RegWriteD, MemtoRegD, MemWriteD, ALUSrcD, RegDstD, BranchD;
  logic [2:0]  ALUControlD;

  decode_stage dut (
    .clk        (clk),
    .rst        (rst),
    .StallD     (StallD),
    .InstrF     (InstrF),
    .PCPlus4F   (PCPlus4F),
    .ForwardAD  (ForwardAD),
    .ForwardBD  (ForwardBD),
    .ALUOutM    (ALUOutM),
    .RegWriteW  (RegWriteW),
    .WriteRegW  (WriteRegW),
    .ResultW    (ResultW),
    .PCSrcD     (PCSrcD),
    .Jump       (Jump),
    .PCBranchD  (PCBranchD),
    .PCJumpD    (PCJumpD),
    .RD1D       (RD1D),
    .RD2D       (RD2D),
    .RsD        (RsD),
    .RtD        (RtD),
    .RdD        (RdD),
    .SignImmD   (SignImmD),
    .RegWriteD  (RegWriteD),
    .MemtoRegD  (MemtoRegD),
    .MemWriteD  (MemWriteD),
    .ALUSrcD    (ALUSrcD),
    .RegDstD    (RegDstD),
    .BranchD    (BranchD),
    .ALUControlD(ALUControlD)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef enum {
    S_RD1, S_RD2, S_PCSRC, S_JUMP, S_PCBR, S_PCJ, S_RS, S_RT, S_RD,
    S_REGW, S_M2R, S_MEMW, S_ALUSRC, S_REGDST, S_BR, S_ALUC, S_IMM
  } sel_t;

  typedef struct {
    string       tag;
    sel_t        sel;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] observe(input sel_t s);
    case (s)
      S_RD1:    return RD1D;
      S_RD2:    return RD2D;
      S_PCSRC:  return {31'b0, PCSrcD};
      S_JUMP:   return {31'b0, Jump};
      S_PCBR:   return PCBranchD;
      S_PCJ:    return PCJumpD;
      S_RS:     return {27'b0, RsD};
      S_RT:     return {27'b0, RtD};
      S_RD:     return {27'b0, RdD};
      S_REGW:   return {31'b0, RegWriteD};
      S_M2R:    return {31'b0, MemtoRegD};
      S_MEMW:   return {31'b0, MemWriteD};
      S_ALUSRC: return {31'b0, ALUSrcD};
      S_REGDST: return {31'b0, RegDstD};
      S_BR:     return {31'b0, BranchD};
      S_ALUC:   return {29'b0, ALUControlD};
      default:  return SignImmD;
    endcase
  endfunction

  task automatic push_exp(input string tag, input sel_t s, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.sel = s;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check_val(e.tag, observe(e.sel), e.val);
    end
  endtask

  // A zeroed IF/ID register decodes as an unknown-funct R-type with zero targets.
  task automatic push_idle(input string pfx);
    push_exp({pfx, "_rs"},     S_RS,     32'h0);
    push_exp({pfx, "_rt"},     S_RT,     32'h0);
    push_exp({pfx, "_rd"},     S_RD,     32'h0);
    push_exp({pfx, "_regdst"}, S_REGDST, 32'h1);
    push_exp({pfx, "_regw"},   S_REGW,   32'h0);
    push_exp({pfx, "_memw"},   S_MEMW,   32'h0);
    push_exp({pfx, "_br"},     S_BR,     32'h0);
    push_exp({pfx, "_aluc"},   S_ALUC,   32'h0);
    push_exp({pfx, "_pcsrc"},  S_PCSRC,  32'h0);
    push_exp({pfx, "_jump"},   S_JUMP,   32'h0);
    push_exp({pfx, "_pcbr"},   S_PCBR,   32'h0);
    push_exp({pfx, "_pcj"},    S_PCJ,    32'h0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_reg(input logic [4:0] a, input logic [31:0] v);
    RegWriteW = 1'b1;
    WriteRegW = a;
    ResultW   = v;
    tick();
    RegWriteW = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset state
    #2;
    push_idle("rst");
    push_exp("rst_rd1", S_RD1, 32'h0);
    push_exp("rst_rd2", S_RD2, 32'h0);
    drain();
    #4 rst = 1'b0;

    // Reset then write $8, add $t1,$t0,$t0 reaches decode
    InstrF = 32'h01084820;
    PCPlus4F = 32'h4;
    wr_reg(5'd8, 32'h12345678);
    push_exp("add_rd1",    S_RD1,    32'h12345678);
    push_exp("add_rd2",    S_RD2,    32'h12345678);
    push_exp("add_regw",   S_REGW,   32'h1);
    push_exp("add_regdst", S_REGDST, 32'h1);
    push_exp("add_aluc",   S_ALUC,   32'h2);
    push_exp("add_rs",     S_RS,     32'h8);
    push_exp("add_rt",     S_RT,     32'h8);
    push_exp("add_rd",     S_RD,     32'h9);
    push_exp("add_pcsrc",  S_PCSRC,  32'h0);
    drain();

    // Same-cycle write-through bypass
    RegWriteW = 1'b1;
    WriteRegW = 5'd8;
    ResultW   = 32'hAA;
    push_exp("byp_rd1", S_RD1, 32'hAA);
    push_exp("byp_rd2", S_RD2, 32'hAA);
    drain();
    InstrF = 32'h00001820;
    tick();
    WriteRegW = 5'd0;
    ResultW   = 32'hFF;
    push_exp("r0_byp_rd1", S_RD1, 32'h0);
    push_exp("r0_byp_rd2", S_RD2, 32'h0);
    push_exp("r0_rd",      S_RD,  32'h3);
    drain();
    tick();
    RegWriteW = 1'b0;
    push_exp("r0_kept_rd1", S_RD1, 32'h0);
    drain();
    InstrF = 32'h01084820;
    tick();
    push_exp("r8_stored", S_RD1, 32'hAA);
    drain();

    // Taken beq with negative offset, then flush
    InstrF = 32'h0;
    wr_reg(5'd1, 32'd5);
    wr_reg(5'd2, 32'd5);
    InstrF = 32'h1022FFFF;
    PCPlus4F = 32'h10;
    tick();
    push_exp("beq_pcsrc",  S_PCSRC,  32'h1);
    push_exp("beq_pcbr",   S_PCBR,   32'h0000000C);
    push_exp("beq_br",     S_BR,     32'h1);
    push_exp("beq_aluc",   S_ALUC,   32'h6);
    push_exp("beq_regw",   S_REGW,   32'h0);
    push_exp("beq_regdst", S_REGDST, 32'h0);
    push_exp("beq_imm",    S_IMM,    32'hFFFFFFFF);
    push_exp("beq_rd1",    S_RD1,    32'h5);
    drain();
    InstrF = 32'h01084820;
    tick();
    push_idle("beq_flush");
    drain();

    // Branch target wrap-around
    InstrF = 32'h10220001;
    PCPlus4F = 32'hFFFFFFFC;
    tick();
    push_exp("wrap_pcsrc", S_PCSRC, 32'h1);
    push_exp("wrap_pcbr",  S_PCBR,  32'h0);
    push_exp("wrap_imm",   S_IMM,   32'h1);
    drain();
    tick();
    push_idle("wrap_flush");
    drain();

    // Forwarded bne
    InstrF = 32'h0;
    wr_reg(5'd3, 32'd3);
    wr_reg(5'd4, 32'd3);
    InstrF = 32'h14640002;
    PCPlus4F = 32'h100;
    tick();
    ForwardAD = 1'b1;
    ALUOutM = 32'd3;
    push_exp("bne_eq_pcsrc", S_PCSRC, 32'h0);
    push_exp("bne_br",       S_BR,    32'h1);
    push_exp("bne_rd1",      S_RD1,   32'h3);
    push_exp("bne_rd2",      S_RD2,   32'h3);
    drain();
    ALUOutM = 32'd4;
    push_exp("bne_ne_pcsrc", S_PCSRC, 32'h1);
    push_exp("bne_pcbr",     S_PCBR,  32'h108);
    drain();
    ForwardBD = 1'b1;
    push_exp("bne_fwdab_pcsrc", S_PCSRC, 32'h0);
    drain();
    ForwardBD = 1'b0;
    push_exp("bne_fwda_pcsrc", S_PCSRC, 32'h1);
    drain();
    InstrF = 32'h0;
    tick();
    push_idle("bne_flush");
    drain();
    ForwardAD = 1'b0;

    // Jump, then flush
    PCPlus4F = 32'h40000004;
    InstrF = 32'h08000040;
    tick();
    push_exp("j_jump",   S_JUMP,   32'h1);
    push_exp("j_pcj",    S_PCJ,    32'h40000100);
    push_exp("j_regdst", S_REGDST, 32'h0);
    push_exp("j_regw",   S_REGW,   32'h0);
    push_exp("j_pcsrc",  S_PCSRC,  32'h0);
    drain();
    tick();
    push_idle("j_flush");
    drain();

    // Stall holds a taken branch, release flushes
    InstrF = 32'h1022FFFF;
    PCPlus4F = 32'h10;
    tick();
    StallD = 1'b1;
    InstrF = 32'h01084820;
    for (int i = 0; i < 2; i++) begin
      tick();
      push_exp("stall_pcsrc", S_PCSRC, 32'h1);
      push_exp("stall_rs",    S_RS,    32'h1);
      push_exp("stall_rt",    S_RT,    32'h2);
      push_exp("stall_pcbr",  S_PCBR,  32'h0000000C);
      drain();
    end
    StallD = 1'b0;
    tick();
    push_idle("unstall_flush");
    drain();

    // Async reset in the middle of a stall
    InstrF = 32'h1022FFFF;
    tick();
    StallD = 1'b1;
    tick();
    push_exp("pre_rst_pcsrc", S_PCSRC, 32'h1);
    drain();
    rst = 1'b1;
    push_idle("mid_rst");
    push_exp("mid_rst_rd1", S_RD1, 32'h0);
    drain();
    rst = 1'b0;
    StallD = 1'b0;
    tick();
    push_exp("post_rst_rd1",   S_RD1,   32'h0);
    push_exp("post_rst_rd2",   S_RD2,   32'h0);
    push_exp("post_rst_rs",    S_RS,    32'h1);
    push_exp("post_rst_pcsrc", S_PCSRC, 32'h1);
    push_exp("post_rst_pcbr",  S_PCBR,  32'h0000000C);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
